regbank_arbiter: RTL and testbench

- Shares the 8x8 register bank (one registered write port, two registered read ports, rw-selected per cycle) between two requesters: port 0 (core datapath) and port 1 (debug/loader).
- Accepts one operation at a time through a valid/ready handshake, drives the bank's rw/index/data inputs from registers, and returns read data with a per-port response strobe.
- Sits between the requesters and register_bank, and is the only driver of the bank's inputs.

---
 rtl/regbank_arbiter.sv | 120 ++++++++++++
 tb/tb_regbank_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// Purpose : two-port valid/ready arbiter that owns every input of the 8x8 register bank.
// Latency : read accept -> rsp_valid 2 cycles (3 cycles per read), write 2 cycles per op.
// Backpressure: req_ready is only raised in IDLE, so a second op waits for the current one.
// Ports   : clk/rst; req_* request side (valid/ready/we, per-port indices and write data);
//           rsp_valid/rsp_a/rsp_b read return; bank_* drive and read back the register bank.
module regbank_arbiter #(
  parameter int DW         = 8,
  parameter int AW         = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_ra0,
  input  logic [AW-1:0] req_rb0,
  input  logic [AW-1:0] req_rd0,
  input  logic [AW-1:0] req_ra1,
  input  logic [AW-1:0] req_rb1,
  input  logic [AW-1:0] req_rd1,
  input  logic [DW-1:0] req_wd0,
  input  logic [DW-1:0] req_wd1,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic          bank_rw,
  output logic [AW-1:0] bank_ri_a,
  output logic [AW-1:0] bank_ri_b,
  output logic [AW-1:0] bank_ri_d,
  output logic [DW-1:0] bank_d,
  input  logic [DW-1:0] bank_a,
  input  logic [DW-1:0] bank_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state;
  logic       last_port;  // port granted most recently; 1 after reset so port 0 wins the first tie
  logic       op_port;    // owner of the operation in flight
  logic       op_we;      // operation in flight is a write
  logic [1:0] grant;
  logic       win;
  logic       accept;

  // Grant is only offered in IDLE; a lone requester always wins, a tie goes by mode.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (req_valid == 2'b11) begin
        if (FIXED_PRIO != 0 || last_port)
          grant = 2'b01;
        else
          grant = 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  assign req_ready = grant;
  assign win       = grant[1];
  assign accept    = |grant;

  // Bank read data is passed straight through; rsp_valid qualifies it.
  assign rsp_a = bank_a;
  assign rsp_b = bank_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_port <= 1'b1;
      op_port   <= 1'b0;
      op_we     <= 1'b0;
      bank_rw   <= 1'b0;
      bank_ri_a <= '0;
      bank_ri_b <= '0;
      bank_ri_d <= '0;
      bank_d    <= '0;
      rsp_valid <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 2'b00;
          if (accept) begin
            last_port <= win;
            op_port   <= win;
            op_we     <= req_we[win];
            bank_rw   <= req_we[win];
            bank_ri_a <= win ? req_ra1 : req_ra0;
            bank_ri_b <= win ? req_rb1 : req_rb0;
            bank_ri_d <= win ? req_rd1 : req_rd0;
            bank_d    <= win ? req_wd1 : req_wd0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Bank samples at the end of this cycle; rw must be low again afterwards.
          bank_rw <= 1'b0;
          if (op_we) begin
            state <= IDLE;
          end else begin
            rsp_valid <= op_port ? 2'b10 : 2'b01;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 2'b00;
          bank_rw   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;

  typedef struct packed {
    logic       vld;
    logic       we;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rd;
    logic [7:0] wd;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  req_t rq [2][2];  // [dut][port]; dut 0 is round-robin, dut 1 fixed priority

  logic [1:0] rdy  [2];
  logic [1:0] rspv [2];
  logic [7:0] rspa [2];
  logic [7:0] rspb [2];
  logic       brw  [2];
  logic [2:0] bra  [2];
  logic [2:0] brb  [2];
  logic [2:0] brd  [2];
  logic [7:0] bd   [2];

  int tick   = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int rw_cnt [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    // Register bank: one registered write port, two registered read ports, rw-selected.
    logic [7:0] mem [8] = '{default: 8'h00};
    logic [7:0] a_q = 8'h00;
    logic [7:0] b_q = 8'h00;
    always @(posedge clk) begin
      if (brw[k]) mem[brd[k]] <= bd[k];
      else begin
        a_q <= mem[bra[k]];
        b_q <= mem[brb[k]];
      end
    end

    regbank_arbiter #(.DW(8), .AW(3), .FIXED_PRIO(k)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid ({rq[k][1].vld, rq[k][0].vld}),
      .req_ready (rdy[k]),
      .req_we    ({rq[k][1].we, rq[k][0].we}),
      .req_ra0   (rq[k][0].ra),
      .req_rb0   (rq[k][0].rb),
      .req_rd0   (rq[k][0].rd),
      .req_ra1   (rq[k][1].ra),
      .req_rb1   (rq[k][1].rb),
      .req_rd1   (rq[k][1].rd),
      .req_wd0   (rq[k][0].wd),
      .req_wd1   (rq[k][1].wd),
      .rsp_valid (rspv[k]),
      .rsp_a     (rspa[k]),
      .rsp_b     (rspb[k]),
      .bank_rw   (brw[k]),
      .bank_ri_a (bra[k]),
      .bank_ri_b (brb[k]),
      .bank_ri_d (brd[k]),
      .bank_d    (bd[k]),
      .bank_a    (a_q),
      .bank_b    (b_q)
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  // Tracks, per DUT, when the next acceptance may happen, which interval carries
  // bank_rw / the response, and a register image updated at the write commit edge.
  logic [7:0] mmem    [2][8] = '{default: 8'h00};
  logic       mlast   [2]    = '{1'b1, 1'b1};
  int         nf      [2]    = '{0, 0};
  int         rw_at   [2]    = '{-10, -10};
  int         rsp_at  [2]    = '{-10, -10};
  logic       mrsp_p  [2]    = '{1'b0, 1'b0};
  logic [7:0] ea      [2]    = '{8'h00, 8'h00};
  logic [7:0] eb      [2]    = '{8'h00, 8'h00};
  logic       pend_v  [2]    = '{1'b0, 1'b0};
  int         pend_at [2]    = '{0, 0};
  logic [2:0] pend_d  [2]    = '{3'd0, 3'd0};
  logic [7:0] pend_w  [2]    = '{8'h00, 8'h00};
  logic [1:0] m_g;
  logic       m_p;
  req_t       m_r;

  function automatic logic [1:0] exp_grant(input int k, input logic [1:0] v, input logic last);
    if (v != 2'b11) return v;      // lone requester (or none)
    if (k == 1) return 2'b01;      // fixed priority: port 0
    return last ? 2'b01 : 2'b10;   // round robin: the port not granted last
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mlast[k]  = 1'b1;
        nf[k]     = 0;
        rw_at[k]  = -10;
        rsp_at[k] = -10;
        pend_v[k] = 1'b0;
      end else begin
        if (pend_v[k] && pend_at[k] == tick) begin
          mmem[k][pend_d[k]] = pend_w[k];
          pend_v[k] = 1'b0;
        end
        if (tick >= nf[k]) begin
          m_g = exp_grant(k, {rq[k][1].vld, rq[k][0].vld}, mlast[k]);
          if (m_g != 2'b00) begin
            m_p      = m_g[1];
            mlast[k] = m_p;
            m_r      = rq[k][m_p];
            if (m_r.we) begin
              pend_v[k]  = 1'b1;
              pend_at[k] = tick + 1;
              pend_d[k]  = m_r.rd;
              pend_w[k]  = m_r.wd;
              rw_at[k]   = tick;
              nf[k]      = tick + 2;
            end else begin
              rsp_at[k] = tick + 1;
              mrsp_p[k] = m_p;
              ea[k]     = mmem[k][m_r.ra];
              eb[k]     = mmem[k][m_r.rb];
              nf[k]     = tick + 3;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  logic [1:0] c_er, c_ev;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      c_er = (tick >= nf[k]) ? exp_grant(k, {rq[k][1].vld, rq[k][0].vld}, mlast[k]) : 2'b00;
      chk($sformatf("req_ready dut%0d", k), int'(rdy[k]), int'(c_er));
      chk($sformatf("bank_rw dut%0d", k), int'(brw[k]), int'(rw_at[k] == tick - 1));
      c_ev = (rsp_at[k] == tick - 1) ? (mrsp_p[k] ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rsp_valid dut%0d", k), int'(rspv[k]), int'(c_ev));
      if (c_ev != 2'b00) begin
        chk($sformatf("rsp_a dut%0d", k), int'(rspa[k]), int'(ea[k]));
        chk($sformatf("rsp_b dut%0d", k), int'(rspb[k]), int'(eb[k]));
      end
      if (brw[k]) rw_cnt[k] = rw_cnt[k] + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input int k, input int p, input logic vld, input logic we,
                     input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                     input logic [7:0] wd);
    rq[k][p].vld = vld;
    rq[k][p].we  = we;
    rq[k][p].ra  = ra;
    rq[k][p].rb  = rb;
    rq[k][p].rd  = rd;
    rq[k][p].wd  = wd;
  endtask

  // Waits for an acceptance on dut k; returns its edge index and grant, then
  // resumes just after that edge so the caller can update requests.
  task automatic wait_acc(input int k, output int e, output logic [1:0] g);
    e = -1;
    g = 2'b00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      g = rdy[k] & {rq[k][1].vld, rq[k][0].vld};
      if (!rst && g != 2'b00) begin
        e = tick;
        break;
      end
    end
    if (e < 0) begin
      n_chk++;
      $display("FAIL accept timeout dut%0d: got none, expected an acceptance", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int k, output int c, output logic [1:0] pv,
                          output logic [7:0] a, output logic [7:0] b);
    c  = -1;
    pv = 2'b00;
    a  = 8'h00;
    b  = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rspv[k] != 2'b00) begin
        c  = tick;
        pv = rspv[k];
        a  = rspa[k];
        b  = rspb[k];
        break;
      end
    end
    if (c < 0) begin
      n_chk++;
      $display("FAIL response timeout dut%0d: got none, expected rsp_valid", k);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2, e3, base, c, rc0;
    logic [1:0] g, pv;
    logic [7:0] a, b;

    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) rq[k][p] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset bank_rw", int'(brw[0]), 0);
    chk("reset rsp_valid", int'(rspv[0]), 0);
    chk("reset bank_ri_d", int'(brd[0]), 0);
    chk("reset bank_d", int'(bd[0]), 0);
    rst = 1'b0;

    // 1: port 0 writes r3=A5 then reads ra=3 rb=0.
    base = tick;
    put(0, 0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd3, 8'hA5);
    wait_acc(0, e0, g);
    chk("t1 write accept cycle", e0 - base, 0);
    chk("t1 write grant", int'(g), 1);
    put(0, 0, 1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 8'h00);
    wait_acc(0, e1, g);
    chk("t1 read accept cycle", e1 - base, 2);
    put(0, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_rsp(0, c, pv, a, b);
    chk("t1 rsp cycle", c - base, 4);
    chk("t1 rsp port", int'(pv), 1);
    chk("t1 rsp_a", int'(a), 8'hA5);
    chk("t1 rsp_b", int'(b), 8'h00);

    // 2: both ports hold reads, round robin; port 0 was granted last.
    put(0, 0, 1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 8'h00);
    put(0, 1, 1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 8'h00);
    e0 = 0;
    for (int i = 0; i < 4; i++) begin
      wait_acc(0, e1, g);
      chk($sformatf("t2 grant %0d", i), int'(g), (i % 2 == 0) ? 2 : 1);
      if (i > 0) chk($sformatf("t2 spacing %0d", i), e1 - e0, 3);
      e0 = e1;
    end
    put(0, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    put(0, 1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    // 3: fixed priority, both valid; port 0 takes three reads then withdraws.
    put(1, 0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00);
    put(1, 1, 1'b1, 1'b0, 3'd4, 3'd5, 3'd0, 8'h00);
    e0 = 0;
    for (int i = 0; i < 3; i++) begin
      wait_acc(1, e1, g);
      chk($sformatf("t3 grant %0d", i), int'(g), 1);
      e0 = e1;
    end
    put(1, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_acc(1, e1, g);
    chk("t3 port1 grant", int'(g), 2);
    chk("t3 port1 spacing", e1 - e0, 3);
    put(1, 1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    // 4: same cycle: port 1 writes r7=FF, port 0 reads r7; port 1 favoured.
    put(0, 1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 8'hFF);
    put(0, 0, 1'b1, 1'b0, 3'd7, 3'd7, 3'd0, 8'h00);
    wait_acc(0, e0, g);
    chk("t4 first grant", int'(g), 2);
    put(0, 1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_acc(0, e1, g);
    chk("t4 second grant", int'(g), 1);
    chk("t4 spacing", e1 - e0, 2);
    put(0, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_rsp(0, c, pv, a, b);
    chk("t4 rsp port", int'(pv), 1);
    chk("t4 rsp_a", int'(a), 8'hFF);
    chk("t4 rsp_b", int'(b), 8'hFF);

    // 5: reset during ISSUE of a write r2=55 aborts it.
    put(0, 0, 1'b1, 1'b1, 3'd5, 3'd6, 3'd2, 8'h55);
    wait_acc(0, e0, g);
    put(0, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("t5 bank_rw on reset", int'(brw[0]), 0);
    chk("t5 bank_ri_a on reset", int'(bra[0]), 0);
    chk("t5 bank_ri_d on reset", int'(brd[0]), 0);
    chk("t5 bank_d on reset", int'(bd[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    put(0, 0, 1'b1, 1'b0, 3'd2, 3'd7, 3'd0, 8'h00);
    wait_acc(0, e0, g);
    put(0, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_rsp(0, c, pv, a, b);
    chk("t5 rsp port", int'(pv), 1);
    chk("t5 old r2", int'(a), 8'h00);
    chk("t5 r7 kept", int'(b), 8'hFF);

    // 6: port 0 alone, alternating write / read with valid held.
    rc0 = rw_cnt[0];
    put(0, 0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd1, 8'h11);
    wait_acc(0, e0, g);
    put(0, 0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00);
    wait_acc(0, e1, g);
    chk("t6 write->read spacing", e1 - e0, 2);
    put(0, 0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 8'h22);
    wait_acc(0, e2, g);
    chk("t6 read->write spacing", e2 - e1, 3);
    put(0, 0, 1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 8'h00);
    wait_acc(0, e3, g);
    chk("t6 write->read spacing 2", e3 - e2, 2);
    put(0, 0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    wait_rsp(0, c, pv, a, b);
    chk("t6 rsp_a", int'(a), 8'h22);
    chk("t6 rsp_b", int'(b), 8'h11);
    repeat (2) @(posedge clk);
    #1;
    chk("t6 bank_rw cycles", rw_cnt[0] - rc0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
